mdu_unit: RTL and testbench

//   E-stage multiply/divide unit: executes the 5-bit HILOOp code issued by the decoder.

---
 rtl/mdu_unit.sv | 115 +++++++++++
 tb/tb_mdu_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, holds mult/div results in a pending
// register and commits them after a fixed busy latency.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  HILOOp,
  input  logic        en,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILOOut
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_ok;

  logic        w_is_mult;
  logic        w_is_div;
  logic        w_signed_div;
  logic        w_neg_q;
  logic        w_neg_r;
  logic        w_idle_en;
  logic [31:0] w_dv_a;
  logic [31:0] w_dv_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;

  always_comb begin
    w_is_mult    = (HILOOp == OP_MULT) || (HILOOp == OP_MULTU);
    w_is_div     = (HILOOp == OP_DIV)  || (HILOOp == OP_DIVU);
    w_signed_div = (HILOOp == OP_DIV);

    // One shared 64-bit multiplier: the low 64 bits of an extended product are
    // correct for both signed and unsigned operands.
    w_a_ext = (HILOOp == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
    w_b_ext = (HILOOp == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
    w_prod  = w_a_ext * w_b_ext;

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    w_dv_a  = (w_signed_div && A[31]) ? (32'd0 - A) : A;
    w_dv_b  = (w_signed_div && B[31]) ? (32'd0 - B) : B;
    w_q_mag = w_dv_a / w_dv_b;
    w_r_mag = w_dv_a % w_dv_b;
    w_neg_q = w_signed_div && (A[31] ^ B[31]);
    w_neg_r = w_signed_div && A[31];
    w_q     = w_neg_q ? (32'd0 - w_q_mag) : w_q_mag;
    w_r     = w_neg_r ? (32'd0 - w_r_mag) : w_r_mag;

    Busy      = (r_cnt != 4'd0);
    w_idle_en = en && !Busy;
    Start     = w_idle_en && (w_is_mult || w_is_div);

    HILOOut = 32'd0;
    if (HILOOp == OP_MFHI) HILOOut = r_hi;
    else if (HILOOp == OP_MFLO) HILOOut = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else if (Start) begin
      r_cnt <= w_is_mult ? MULT_N : DIV_N;
      if (w_is_mult) begin
        r_pend_hi <= w_prod[63:32];
        r_pend_lo <= w_prod[31:0];
      end else begin
        r_pend_hi <= w_r;
        r_pend_lo <= w_q;
      end
      // A zero divisor still costs the full latency but never commits.
      r_pend_ok <= !(w_is_div && (B == 32'd0));
    end else if (Busy) begin
      r_cnt <= r_cnt - 4'd1;
      if ((r_cnt == 4'd1) && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_idle_en && (HILOOp == OP_MTHI)) begin
      r_hi <= A;
    end else if (w_idle_en && (HILOOp == OP_MTLO)) begin
      r_lo <= A;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed scenarios plus randomized ops, checked against a
// cycle-level arithmetic model of HI/LO, busy latency and pending results.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  op = 5'd0;
  logic        en = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] out;

  int vec  = 0;
  int errs = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          m_left = 0;
  bit          m_ok = 1'b0;

  logic        obs_start, obs_busy, exp_start, exp_busy;
  logic [31:0] obs_out, exp_out;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .HILOOp(op), .en(en), .A(a), .B(b),
    .Start(start), .Busy(busy), .HILOOut(out)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive, sample combinational outputs, advance model, sample Busy.
  task automatic step(input bit rst, input logic [4:0] o, input bit e,
                      input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] p;
    logic [63:0] qv, rv;
    longint q, r;
    @(negedge clk);
    reset = rst; op = o; en = e; a = av; b = bv;
    #1;
    obs_start = start;
    obs_out   = out;
    exp_start = e && (m_left == 0) && (o >= 5'd1) && (o <= 5'd4);
    exp_out   = (o == 5'd5) ? m_hi : (o == 5'd6) ? m_lo : 32'd0;
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_ok = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (exp_start) begin
      m_left = (o <= 5'd2) ? 5 : 10;
      m_ok   = 1'b1;
      case (o)
        5'd1: begin
          p = longint'($signed(av)) * longint'($signed(bv));
          m_phi = p[63:32]; m_plo = p[31:0];
        end
        5'd2: begin
          p = {32'd0, av} * {32'd0, bv};
          m_phi = p[63:32]; m_plo = p[31:0];
        end
        5'd3: begin
          if (bv == 0) m_ok = 1'b0;
          else begin
            q = longint'($signed(av)) / longint'($signed(bv));
            r = longint'($signed(av)) % longint'($signed(bv));
            qv = q; rv = r;
            m_plo = qv[31:0]; m_phi = rv[31:0];
          end
        end
        default: begin
          if (bv == 0) m_ok = 1'b0;
          else begin
            m_plo = av / bv; m_phi = av % bv;
          end
        end
      endcase
    end else if (e && o == 5'd7) begin
      m_hi = av;
    end else if (e && o == 5'd8) begin
      m_lo = av;
    end
    #1;
    obs_busy = busy;
    exp_busy = (m_left != 0);
  endtask

  // Counts busy cycles following a start step, bounded at 20 cycles.
  task automatic wait_idle(output int n);
    n = obs_busy ? 1 : 0;
    for (int i = 0; i < 20 && obs_busy; i++) begin
      step(0, 5'd0, 1, 32'd0, 32'd0);
      if (obs_busy) n++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    step(0, 5'd5, 1, 32'd0, 32'd0); hi = obs_out;
    step(0, 5'd6, 1, 32'd0, 32'd0); lo = obs_out;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    step(1, 5'd0, 0, 32'd0, 32'd0);
    step(1, 5'd0, 0, 32'd0, 32'd0);
    vec++; if (obs_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0b want=0", obs_busy); end
    read_hilo(hi, lo);
    vec++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int n_want,
                        input logic [31:0] hi_want, input logic [31:0] lo_want);
    int n;
    logic [31:0] hi, lo;
    step(0, o, 1, av, bv);
    vec++; if (obs_start !== 1'b1) begin errs++; $display("FAIL %s_start got=%0b want=1", name, obs_start); end
    wait_idle(n);
    vec++; if (n != n_want) begin errs++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, n, n_want); end
    read_hilo(hi, lo);
    vec++; if (hi !== hi_want || lo !== lo_want) begin
      errs++; $display("FAIL %s_result got=%h/%h want=%h/%h", name, hi, lo, hi_want, lo_want);
    end
    $display("op %s A=%h B=%h busy=%0d HI=%h LO=%h", name, av, bv, n, hi, lo);
  endtask

  task automatic test_mult();
    run_op("mult",  5'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 5'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_div();
    run_op("div",     5'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 5'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divu",    5'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14);
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    step(0, 5'd7, 1, 32'h1234, 32'd0);
    step(0, 5'd8, 1, 32'h5678, 32'd0);
    read_hilo(hi, lo);
    vec++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
      errs++; $display("FAIL mt_write got=%h/%h want=1234/5678", hi, lo);
    end
    run_op("divu_zero", 5'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("div_zero",  5'd3, 32'hFFFFFF00, 32'd0, 10, 32'h1234, 32'h5678);
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [31:0] hi, lo;
    step(0, 5'd1, 1, 32'd3, 32'd4);
    step(0, 5'd1, 1, 32'd7, 32'd7);
    vec++; if (obs_start !== 1'b0) begin errs++; $display("FAIL busy_restart got=%0b want=0", obs_start); end
    step(0, 5'd8, 1, 32'hDEAD, 32'd0);
    vec++; if (obs_start !== 1'b0) begin errs++; $display("FAIL busy_mtlo_start got=%0b want=0", obs_start); end
    step(0, 5'd5, 1, 32'd0, 32'd0);
    vec++; if (obs_out !== 32'h1234) begin errs++; $display("FAIL busy_mfhi got=%h want=00001234", obs_out); end
    wait_idle(n);
    read_hilo(hi, lo);
    vec++; if (hi !== 32'd0 || lo !== 32'd12) begin
      errs++; $display("FAIL busy_commit got=%h/%h want=0/c", hi, lo);
    end
    step(0, 5'd1, 0, 32'd5, 32'd6);
    vec++; if (obs_start !== 1'b0 || obs_busy !== 1'b0) begin
      errs++; $display("FAIL en0_mult got start=%0b busy=%0b want 0/0", obs_start, obs_busy);
    end
    $display("busy_ignore HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    step(0, 5'd4, 1, 32'd100, 32'd7);
    step(0, 5'd0, 1, 32'd0, 32'd0);
    step(0, 5'd0, 1, 32'd0, 32'd0);
    step(1, 5'd0, 1, 32'd0, 32'd0);
    vec++; if (obs_busy !== 1'b0) begin errs++; $display("FAIL midreset_busy got=%0b want=0", obs_busy); end
    read_hilo(hi, lo);
    vec++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL midreset_hilo got=%h/%h want=0/0", hi, lo);
    end
    step(0, 5'd0, 1, 32'd0, 32'd0);
    step(0, 5'd0, 1, 32'd0, 32'd0);
    vec++; if (obs_busy !== 1'b0) begin errs++; $display("FAIL midreset_stale got=%0b want=0", obs_busy); end
    $display("reset_mid HI=%h LO=%h", hi, lo);
  endtask

  task automatic test_random();
    logic [4:0]  o;
    logic [31:0] av, bv;
    bit e, rst;
    for (int i = 0; i < 400; i++) begin
      o   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
      e   = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 79) == 0);
      av  = $urandom;
      bv  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 15) == 0) av = 32'h80000000;
      step(rst, o, e, av, bv);
      vec++; if (obs_start !== exp_start) begin errs++; $display("FAIL rnd_start i=%0d got=%0b want=%0b", i, obs_start, exp_start); end
      vec++; if (obs_out !== exp_out) begin errs++; $display("FAIL rnd_out i=%0d op=%0d got=%h want=%h", i, o, obs_out, exp_out); end
      vec++; if (obs_busy !== exp_busy) begin errs++; $display("FAIL rnd_busy i=%0d got=%0b want=%0b", i, obs_busy, exp_busy); end
      $display("rnd %0d rst=%0b op=%0d en=%0b A=%h B=%h out=%h busy=%0b", i, rst, o, e, av, bv, obs_out, obs_busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
